// File: rtl/pio_led_blink_port_if.sv
// Avalon-MM slave bus bundle for the LED PIO.
// Master drives the request side; slave returns zero-wait read data.
interface pio_led_blink_port_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_led_blink_port.sv
// LED output PIO with atomic set/clear/toggle and per-bit blink.
// A shared prescaler flips the blink phase every BLINK_DIV+1 cycles.
module pio_led_blink_port #(
  parameter int WIDTH = 18,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  pio_led_blink_port_if.slave bus,
  output logic [WIDTH-1:0] out_port
);

  logic             wr;
  logic [7:0]       sel;
  logic [WIDTH-1:0] wd;
  logic [DIV_W-1:0] wdiv;

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] blink_en;
  logic [DIV_W-1:0] blink_div;
  logic [DIV_W-1:0] cnt;
  logic             ph;

  // Bits above WIDTH/DIV_W have no storage behind them.
  logic unused_bits;
  assign unused_bits = ^bus.writedata;

  assign wr   = bus.chipselect & ~bus.write_n;
  assign sel  = 8'b1 << bus.address;
  assign wd   = bus.writedata[WIDTH-1:0];
  assign wdiv = bus.writedata[DIV_W-1:0];

  // DATA: plain write plus atomic set/clear/toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= RESET_VALUE;
    end else if (wr) begin
      unique case (1'b1)
        sel[0]:  data <= wd;
        sel[1]:  data <= data | wd;
        sel[2]:  data <= data & ~wd;
        sel[3]:  data <= data ^ wd;
        default: data <= data;
      endcase
    end
  end

  // Blink mask and prescaler reload value.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_en  <= '0;
      blink_div <= '0;
    end else if (wr) begin
      if (sel[4]) blink_en  <= wd;
      if (sel[5]) blink_div <= wdiv;
    end
  end

  // Prescaler; a BLINK_DIV write restarts the pattern and beats any wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ph  <= 1'b1;
    end else if (wr && sel[5]) begin
      cnt <= wdiv;
      ph  <= 1'b1;
    end else if (blink_div == '0) begin
      cnt <= '0;
      ph  <= 1'b1;
    end else if (cnt == '0) begin
      cnt <= blink_div;
      ph  <= ~ph;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  // Zero-wait read mux; write-only and unused slots read 0.
  always_comb begin
    bus.readdata = '0;
    unique case (1'b1)
      sel[0]:  bus.readdata = 32'(data);
      sel[4]:  bus.readdata = 32'(blink_en);
      sel[5]:  bus.readdata = 32'(blink_div);
      sel[6]:  bus.readdata = {31'b0, ph};
      default: bus.readdata = '0;
    endcase
  end

  assign out_port = data & (~blink_en | {WIDTH{ph}});

endmodule

// File: tb/tb_pio_led_blink_port.sv
// Bench for the LED PIO: directed bus traffic, queued expectations,
// and a negedge monitor that checks every read strobe.
module tb_pio_led_blink_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] out_a;
  logic [3:0]  out_b;

  pio_led_blink_port_if ia ();
  pio_led_blink_port_if ib ();

  pio_led_blink_port #(
    .WIDTH(18), .RESET_VALUE(18'h000F0), .DIV_W(24)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave), .out_port(out_a)
  );

  pio_led_blink_port #(
    .WIDTH(4), .RESET_VALUE(4'h0), .DIV_W(24)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave), .out_port(out_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          b;
    logic [31:0] rd;
    logic [31:0] op;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  task automatic idle();
    ia.chipselect = 1'b0; ia.write_n = 1'b1;
    ia.address = 3'd0; ia.writedata = 32'd0;
    ib.chipselect = 1'b0; ib.write_n = 1'b1;
    ib.address = 3'd0; ib.writedata = 32'd0;
  endtask

  task automatic drive(bit b, logic [2:0] a, logic [31:0] d, bit w);
    if (b) begin
      ib.chipselect = 1'b1; ib.write_n = ~w;
      ib.address = a; ib.writedata = d;
    end else begin
      ia.chipselect = 1'b1; ia.write_n = ~w;
      ia.address = a; ia.writedata = d;
    end
  endtask

  task automatic wr(bit b, logic [2:0] a, logic [31:0] d);
    drive(b, a, d, 1'b1);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rd(bit b, logic [2:0] a, logic [31:0] erd,
                    logic [31:0] eop, string nm);
    exp_t e;
    e.name = nm; e.b = b; e.rd = erd; e.op = eop;
    q.push_back(e);
    drive(b, a, 32'd0, 1'b0);
    @(posedge clk); #1;
    idle();
  endtask

  // Monitor: each read strobe pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] ard, aop;
    if (!reset && ((ia.chipselect && ia.write_n) ||
                   (ib.chipselect && ib.write_n))) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_read: no expectation queued");
      end else begin
        e = q.pop_front();
        ard = e.b ? ib.readdata : ia.readdata;
        aop = e.b ? 32'(out_b) : 32'(out_a);
        checks++;
        if (ard === e.rd) passes++;
        else $display("FAIL %s readdata: got %h want %h",
                      e.name, ard, e.rd);
        checks++;
        if (aop === e.op) passes++;
        else $display("FAIL %s out_port: got %h want %h",
                      e.name, aop, e.op);
      end
    end
  end

  initial begin
    logic ph;
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd(0, 3'd0, 32'hF0, 32'hF0, "rst_data");
    rd(0, 3'd4, 32'h0,  32'hF0, "rst_blink_en");
    rd(0, 3'd5, 32'h0,  32'hF0, "rst_blink_div");
    rd(0, 3'd6, 32'h1,  32'hF0, "rst_status");

    // Atomic update sequence
    wr(0, 3'd0, 32'h3);
    wr(0, 3'd1, 32'h30);
    rd(0, 3'd0, 32'h33, 32'h33, "after_set");
    wr(0, 3'd2, 32'h1);
    rd(0, 3'd0, 32'h32, 32'h32, "after_clear");
    wr(0, 3'd3, 32'h12);
    rd(0, 3'd0, 32'h20, 32'h20, "after_toggle");
    rd(0, 3'd1, 32'h0, 32'h20, "set_reads0");
    rd(0, 3'd2, 32'h0, 32'h20, "clear_reads0");
    rd(0, 3'd3, 32'h0, 32'h20, "toggle_reads0");
    rd(0, 3'd7, 32'h0, 32'h20, "addr7_reads0");

    // Blink with BLINK_DIV=3: 4 cycles on, 4 off
    wr(0, 3'd0, 32'h1);
    wr(0, 3'd4, 32'h1);
    rd(0, 3'd0, 32'h1, 32'h1, "blink_div0_solid");
    wr(0, 3'd5, 32'h3);
    for (int k = 0; k < 16; k++) begin
      ph = ((k / 4) % 2) == 0;
      rd(0, 3'd6, {31'b0, ph}, {31'b0, ph}, "blink_div3");
    end

    // Reprogram on the wrap cycle
    wr(0, 3'd5, 32'h3);
    for (int k = 0; k < 3; k++)
      rd(0, 3'd6, 32'h1, 32'h1, "pre_wrap");
    wr(0, 3'd5, 32'h1);
    for (int k = 0; k < 6; k++) begin
      ph = ((k / 2) % 2) == 0;
      rd(0, 3'd6, {31'b0, ph}, {31'b0, ph}, "div1_restart");
    end

    // Reset mid-blink (phase low) together with a DATA write
    reset = 1'b1;
    drive(0, 3'd0, 32'h2AAAA, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    rd(0, 3'd0, 32'hF0, 32'hF0, "rst2_data");
    rd(0, 3'd4, 32'h0,  32'hF0, "rst2_blink_en");
    rd(0, 3'd5, 32'h0,  32'hF0, "rst2_blink_div");
    rd(0, 3'd6, 32'h1,  32'hF0, "rst2_status");

    // Narrow instance: width truncation and dead address 7
    wr(1, 3'd0, 32'hFFFFFFFF);
    rd(1, 3'd0, 32'hF, 32'hF, "w4_data");
    wr(1, 3'd7, 32'h0);
    rd(1, 3'd0, 32'hF, 32'hF, "w4_addr7_nop");
    rd(1, 3'd7, 32'h0, 32'hF, "w4_addr7_read");
    wr(1, 3'd4, 32'hFFFFFFFF);
    rd(1, 3'd4, 32'hF, 32'hF, "w4_blink_en");
    wr(1, 3'd5, 32'hFFFFFFFF);
    rd(1, 3'd5, 32'h00FFFFFF, 32'hF, "w4_blink_div");
    wr(1, 3'd2, 32'h5);
    rd(1, 3'd0, 32'hA, 32'hA, "w4_clear");

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
